// File: rtl/vga_pkg.sv
// Shared types and constants for the VGA text pipeline.
//   vsched_state_t : vram_wr_sched FSM states
//   VRAM_*_LSB     : field offsets inside a VRAM word {char, red, green, blue}
//   VRAM_DEPTH_DEF : number of VRAM cells (80x60)
package vga_pkg;

  typedef enum logic [1:0] {
    S_IDLE       = 2'd0,
    S_WAIT_FRAME = 2'd1,
    S_CLEAR      = 2'd2
  } vsched_state_t;

  localparam int unsigned VRAM_COLOR_BIT = 4;
  localparam int unsigned VRAM_CHAR_BIT  = 8;
  localparam int unsigned VRAM_BLUE_LSB  = 0;
  localparam int unsigned VRAM_GREEN_LSB = VRAM_BLUE_LSB + VRAM_COLOR_BIT;
  localparam int unsigned VRAM_RED_LSB   = VRAM_GREEN_LSB + VRAM_COLOR_BIT;
  localparam int unsigned VRAM_CHAR_LSB  = VRAM_RED_LSB + VRAM_COLOR_BIT;
  localparam int unsigned VRAM_WORD_BIT  = VRAM_CHAR_LSB + VRAM_CHAR_BIT;

  localparam int unsigned VRAM_DEPTH_DEF = 4800;

endpackage

// File: rtl/rr_arb.sv
// Round-robin arbiter with one-hot combinational grant.
//   i_clk, i_rst_n : clock, async active-low reset
//   i_en           : arbitration enable; pointer only advances on an enabled grant
//   i_req          : request vector
//   o_gnt_c        : one-hot grant (combinational)
//   o_vld_c        : some request won this cycle (combinational)
module rr_arb #(
  parameter int unsigned P_NUM = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  input  logic [P_NUM-1:0] i_req,
  output logic [P_NUM-1:0] o_gnt_c,
  output logic             o_vld_c
);

  localparam int unsigned IDX_W = (P_NUM > 1) ? $clog2(P_NUM) : 1;

  logic [IDX_W-1:0] ptr;
  logic [IDX_W-1:0] win_idx_c;

  // Search starts at ptr and wraps around; first requester found wins.
  always_comb begin
    int unsigned k;
    k         = 0;
    win_idx_c = '0;
    o_vld_c   = 1'b0;
    for (int unsigned i = 0; i < P_NUM; i++) begin
      k = 32'(ptr) + i;
      if (k >= P_NUM) k = k - P_NUM;
      if (!o_vld_c && i_en && i_req[IDX_W'(k)]) begin
        o_vld_c   = 1'b1;
        win_idx_c = IDX_W'(k);
      end
    end
    o_gnt_c = o_vld_c ? (P_NUM'(1) << win_idx_c) : '0;
  end

  // Pointer moves to the index after the last winner.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      ptr <= '0;
    end else if (i_en && o_vld_c) begin
      ptr <= (win_idx_c == IDX_W'(P_NUM - 1)) ? '0 : win_idx_c + IDX_W'(1);
    end
  end

endmodule

// File: rtl/vram_wr_sched.sv
// VRAM write scheduler: round-robin sharing of the VRAM write port between
// requesters plus a full-screen clear engine, optionally restricted to blanking.
//   i_clk, i_rst_n       : clock, async active-low reset
//   i_rgb_on, i_vga_end  : active-video flag and end-of-frame pulse from syncgen
//   i_req/i_adr/i_dt     : packed per-requester write requests (slice k = requester k)
//   o_gnt                : one-hot grant, high in the same cycle as the write
//   i_clr_req, i_clr_dt  : clear request pulse and fill word
//   o_clr_busy/o_clr_done: clear pending-or-sweeping, and end-of-clear pulse
//   o_vram_wr_*          : registered VRAM write port
module vram_wr_sched
  import vga_pkg::*;
#(
  parameter int unsigned P_NUM_REQ    = 2,
  parameter int unsigned P_ADR_BIT    = 13,
  parameter int unsigned P_DT_BIT     = VRAM_WORD_BIT,
  parameter int unsigned P_VRAM_DEPTH = VRAM_DEPTH_DEF,
  parameter int unsigned P_BLANK_ONLY = 1
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rgb_on,
  input  logic                           i_vga_end,
  input  logic [P_NUM_REQ-1:0]           i_req,
  input  logic [P_NUM_REQ*P_ADR_BIT-1:0] i_adr,
  input  logic [P_NUM_REQ*P_DT_BIT-1:0]  i_dt,
  output logic [P_NUM_REQ-1:0]           o_gnt,
  input  logic                           i_clr_req,
  input  logic [P_DT_BIT-1:0]            i_clr_dt,
  output logic                           o_clr_busy,
  output logic                           o_clr_done,
  output logic                           o_vram_wr_en,
  output logic [P_ADR_BIT-1:0]           o_vram_wr_adr,
  output logic [P_DT_BIT-1:0]            o_vram_wr_dt
);

  localparam int unsigned CLR_LAST = P_VRAM_DEPTH - 1;

  vsched_state_t          state;
  logic                   clr_pend;
  logic                   clr_last;
  logic [P_ADR_BIT-1:0]   clr_cnt;

  logic                   win_open_c;
  logic                   arb_en_c;
  logic                   pend_c;
  logic                   arb_vld_c;
  logic [P_NUM_REQ-1:0]   elig_c;
  logic [P_NUM_REQ-1:0]   arb_gnt_c;
  logic [P_ADR_BIT-1:0]   sel_adr_c;
  logic [P_DT_BIT-1:0]    sel_dt_c;

  assign win_open_c = (P_BLANK_ONLY == 0) || !i_rgb_on;
  assign arb_en_c   = win_open_c && (state == S_IDLE);
  assign pend_c     = clr_pend | i_clr_req;
  // A requester whose grant is showing this cycle already has its write.
  assign elig_c     = i_req & ~o_gnt;

  rr_arb #(
    .P_NUM (P_NUM_REQ)
  ) u_arb (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_en    (arb_en_c),
    .i_req   (elig_c),
    .o_gnt_c (arb_gnt_c),
    .o_vld_c (arb_vld_c)
  );

  // Winner's address/data mux.
  always_comb begin
    sel_adr_c = '0;
    sel_dt_c  = '0;
    for (int unsigned k = 0; k < P_NUM_REQ; k++) begin
      if (arb_gnt_c[k]) begin
        sel_adr_c = i_adr[k*P_ADR_BIT +: P_ADR_BIT];
        sel_dt_c  = i_dt[k*P_DT_BIT +: P_DT_BIT];
      end
    end
  end

  // Scheduler FSM with registered write port and status outputs.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state         <= S_IDLE;
      clr_pend      <= 1'b0;
      clr_last      <= 1'b0;
      clr_cnt       <= '0;
      o_gnt         <= '0;
      o_clr_busy    <= 1'b0;
      o_clr_done    <= 1'b0;
      o_vram_wr_en  <= 1'b0;
      o_vram_wr_adr <= '0;
      o_vram_wr_dt  <= '0;
    end else begin
      o_gnt        <= '0;
      o_vram_wr_en <= 1'b0;
      o_clr_done   <= 1'b0;
      case (state)
        S_IDLE: begin
          clr_pend   <= pend_c;
          o_clr_busy <= pend_c;
          if (arb_vld_c) begin
            o_gnt         <= arb_gnt_c;
            o_vram_wr_en  <= 1'b1;
            o_vram_wr_adr <= sel_adr_c;
            o_vram_wr_dt  <= sel_dt_c;
          end else if (pend_c) begin
            state <= S_WAIT_FRAME;
          end
        end
        S_WAIT_FRAME: begin
          o_clr_busy <= 1'b1;
          if (i_vga_end) begin
            state    <= S_CLEAR;
            clr_pend <= 1'b0;
            clr_cnt  <= '0;
            clr_last <= 1'b0;
          end
        end
        S_CLEAR: begin
          clr_pend <= pend_c;
          if (clr_last) begin
            // Last word went out last cycle; a re-request keeps busy high.
            state      <= S_IDLE;
            clr_last   <= 1'b0;
            o_clr_done <= 1'b1;
            o_clr_busy <= pend_c;
          end else begin
            o_clr_busy <= 1'b1;
            if (win_open_c) begin
              o_vram_wr_en  <= 1'b1;
              o_vram_wr_adr <= clr_cnt;
              o_vram_wr_dt  <= i_clr_dt;
              if (clr_cnt == P_ADR_BIT'(CLR_LAST)) begin
                clr_last <= 1'b1;
              end else begin
                clr_cnt <= clr_cnt + P_ADR_BIT'(1);
              end
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_wr_sched.sv
// Directed bench for vram_wr_sched (2 requesters, blank-only writes).
module tb_vram_wr_sched;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned ABIT  = 13;
  localparam int unsigned DBIT  = 20;
  localparam int unsigned DEPTH = 4800;

  logic                   clk = 1'b0;
  logic                   rst_n = 1'b0;
  logic                   rgb_on = 1'b0;
  logic                   vga_end = 1'b0;
  logic [NREQ-1:0]        req = '0;
  logic [NREQ*ABIT-1:0]   adr = '0;
  logic [NREQ*DBIT-1:0]   dt = '0;
  logic [NREQ-1:0]        gnt;
  logic                   clr_req = 1'b0;
  logic [DBIT-1:0]        clr_dt = '0;
  logic                   clr_busy;
  logic                   clr_done;
  logic                   wr_en;
  logic [ABIT-1:0]        wr_adr;
  logic [DBIT-1:0]        wr_dt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vram_wr_sched #(
    .P_NUM_REQ    (NREQ),
    .P_ADR_BIT    (ABIT),
    .P_DT_BIT     (DBIT),
    .P_VRAM_DEPTH (DEPTH),
    .P_BLANK_ONLY (1)
  ) dut (
    .i_clk         (clk),
    .i_rst_n       (rst_n),
    .i_rgb_on      (rgb_on),
    .i_vga_end     (vga_end),
    .i_req         (req),
    .i_adr         (adr),
    .i_dt          (dt),
    .o_gnt         (gnt),
    .i_clr_req     (clr_req),
    .i_clr_dt      (clr_dt),
    .o_clr_busy    (clr_busy),
    .o_clr_done    (clr_done),
    .o_vram_wr_en  (wr_en),
    .o_vram_wr_adr (wr_adr),
    .o_vram_wr_dt  (wr_dt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step();
    step();
    total++; if (gnt !== 2'b00)   begin bad++; $display("FAIL rst_gnt got=%b exp=00", gnt); end
    total++; if (wr_en !== 1'b0)  begin bad++; $display("FAIL rst_wr_en got=%b exp=0", wr_en); end
    total++; if (wr_adr !== '0)   begin bad++; $display("FAIL rst_adr got=%h exp=0", wr_adr); end
    total++; if (wr_dt !== '0)    begin bad++; $display("FAIL rst_dt got=%h exp=0", wr_dt); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", clr_done); end
    rst_n = 1'b1;
    step();
  endtask

  // req0 alone: one-cycle latency, then every other cycle while held.
  task automatic test_single();
    int nwr;
    nwr = 0;
    rgb_on = 1'b0;
    adr[0 +: ABIT] = 13'h0010;
    dt[0 +: DBIT]  = 20'h41F00;
    req = 2'b01;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (wr_en) nwr++;
      if (i == 1) begin
        total++; if (gnt !== 2'b01)     begin bad++; $display("FAIL single_gnt got=%b exp=01", gnt); end
        total++; if (wr_en !== 1'b1)    begin bad++; $display("FAIL single_wr_en got=%b exp=1", wr_en); end
        total++; if (wr_adr !== 13'h0010) begin bad++; $display("FAIL single_adr got=%h exp=0010", wr_adr); end
        total++; if (wr_dt !== 20'h41F00) begin bad++; $display("FAIL single_dt got=%h exp=41f00", wr_dt); end
      end
      if (i == 2) begin
        total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL single_gap got=%b exp=0", wr_en); end
      end
      if (i == 6) req = 2'b00;
    end
    total++; if (nwr != 3) begin bad++; $display("FAIL single_count got=%0d exp=3", nwr); end
  endtask

  // Both held: pointer is at 1 after the last test, so grants go 10,01,10,...
  task automatic test_back_to_back();
    logic [NREQ-1:0] eg;
    logic [ABIT-1:0] ea;
    logic [DBIT-1:0] ed;
    adr = {13'h0200, 13'h0100};
    dt  = {20'h22222, 20'h11111};
    req = 2'b11;
    for (int i = 1; i <= 8; i++) begin
      step();
      eg = (i % 2 == 1) ? 2'b10 : 2'b01;
      ea = (i % 2 == 1) ? 13'h0200 : 13'h0100;
      ed = (i % 2 == 1) ? 20'h22222 : 20'h11111;
      total++; if (gnt !== eg)    begin bad++; $display("FAIL b2b_gnt cyc=%0d got=%b exp=%b", i, gnt, eg); end
      total++; if (wr_en !== 1'b1) begin bad++; $display("FAIL b2b_wr_en cyc=%0d got=%b exp=1", i, wr_en); end
      total++; if (wr_adr !== ea) begin bad++; $display("FAIL b2b_adr cyc=%0d got=%h exp=%h", i, wr_adr, ea); end
      total++; if (wr_dt !== ed)  begin bad++; $display("FAIL b2b_dt cyc=%0d got=%h exp=%h", i, wr_dt, ed); end
    end
    req = 2'b00;
    step();
    step();
  endtask

  // Active video blocks writes; rising rgb_on suppresses the same-cycle decision.
  task automatic test_blank();
    int nwr;
    nwr = 0;
    rgb_on = 1'b1;
    adr[0 +: ABIT] = 13'h0ABC;
    dt[0 +: DBIT]  = 20'h5A5A5;
    req = 2'b01;
    for (int i = 0; i < 100; i++) begin
      step();
      if (wr_en) nwr++;
    end
    total++; if (nwr != 0) begin bad++; $display("FAIL blank_writes got=%0d exp=0", nwr); end
    rgb_on = 1'b0;
    step();
    total++; if (gnt !== 2'b01)       begin bad++; $display("FAIL blank_gnt got=%b exp=01", gnt); end
    total++; if (wr_adr !== 13'h0ABC) begin bad++; $display("FAIL blank_adr got=%h exp=0abc", wr_adr); end
    total++; if (wr_dt !== 20'h5A5A5) begin bad++; $display("FAIL blank_dt got=%h exp=5a5a5", wr_dt); end
    req = 2'b10;
    adr[ABIT +: ABIT] = 13'h0DEF;
    dt[DBIT +: DBIT]  = 20'h12345;
    rgb_on = 1'b1;
    step();
    total++; if (wr_en !== 1'b0) begin bad++; $display("FAIL rise_suppress got=%b exp=0", wr_en); end
    rgb_on = 1'b0;
    step();
    total++; if (gnt !== 2'b10)       begin bad++; $display("FAIL rise_gnt got=%b exp=10", gnt); end
    total++; if (wr_adr !== 13'h0DEF) begin bad++; $display("FAIL rise_adr got=%h exp=0def", wr_adr); end
    req = 2'b00;
    step();
    step();
  endtask

  // Clear sweep(s) with rgb_on toggling and periodic vga_end pulses.
  task automatic test_clear(input int sweeps);
    int  nwr, dones, falls, exp_adr, cyc, tail;
    logic prev_rgb, prev_wr, prev_busy, re_req_done;
    logic [ABIT-1:0] prev_adr;
    nwr = 0; dones = 0; falls = 0; exp_adr = 0; tail = 0;
    prev_rgb = 1'b0; prev_wr = 1'b0; prev_busy = 1'b0; re_req_done = 1'b0;
    prev_adr = '0;
    rgb_on = 1'b0;
    clr_dt = 20'h20000;
    clr_req = 1'b1;
    for (cyc = 1; cyc < 30000 && tail < 4; cyc++) begin
      step();
      if (gnt !== 2'b00) begin total++; bad++; $display("FAIL clr_gnt cyc=%0d got=%b exp=00", cyc, gnt); end
      if (wr_en) begin
        nwr++;
        total++; if (prev_rgb)             begin bad++; $display("FAIL clr_in_video cyc=%0d adr=%0d", cyc, wr_adr); end
        total++; if (wr_adr !== ABIT'(exp_adr)) begin bad++; $display("FAIL clr_adr cyc=%0d got=%0d exp=%0d", cyc, wr_adr, exp_adr); end
        total++; if (wr_dt !== 20'h20000) begin bad++; $display("FAIL clr_dt cyc=%0d got=%h exp=20000", cyc, wr_dt); end
        exp_adr++;
      end
      if (clr_done) begin
        dones++;
        total++; if (!(prev_wr && prev_adr == ABIT'(DEPTH - 1)) || wr_en)
          begin bad++; $display("FAIL clr_done_timing cyc=%0d prev_wr=%b prev_adr=%0d exp=4799", cyc, prev_wr, prev_adr); end
        exp_adr = 0;
      end
      if (prev_busy && !clr_busy) falls++;
      if (dones < sweeps) begin
        total++; if (clr_busy !== 1'b1) begin bad++; $display("FAIL clr_busy cyc=%0d got=%b exp=1", cyc, clr_busy); end
      end else begin
        tail++;
        total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL clr_busy_end cyc=%0d got=%b exp=0", cyc, clr_busy); end
      end
      prev_wr = wr_en; prev_adr = wr_adr; prev_busy = clr_busy;
      clr_req = 1'b0;
      if (sweeps == 2 && !re_req_done && dones == 0 && exp_adr == 1000) begin
        clr_req = 1'b1;
        re_req_done = 1'b1;
      end
      rgb_on  = ((cyc % 7) < 2);
      vga_end = ((cyc % 40) == 10);
      prev_rgb = rgb_on;
    end
    rgb_on = 1'b0; vga_end = 1'b0; clr_req = 1'b0;
    total++; if (dones != sweeps)      begin bad++; $display("FAIL clr_dones got=%0d exp=%0d", dones, sweeps); end
    total++; if (nwr != DEPTH * sweeps) begin bad++; $display("FAIL clr_writes got=%0d exp=%0d", nwr, DEPTH * sweeps); end
    total++; if (falls != 1)           begin bad++; $display("FAIL clr_busy_falls got=%0d exp=1", falls); end
    step();
  endtask

  // Reset at sweep address 2000 aborts the clear; arbitration restarts at 0.
  task automatic test_reset_midclear();
    logic hit;
    int   ndone;
    hit = 1'b0; ndone = 0;
    rgb_on = 1'b0;
    clr_dt = 20'h20000;
    clr_req = 1'b1;
    for (int cyc = 1; cyc < 10000 && !hit; cyc++) begin
      step();
      clr_req = 1'b0;
      vga_end = ((cyc % 40) == 10);
      if (wr_en && wr_adr == 13'd2000) hit = 1'b1;
    end
    vga_end = 1'b0;
    total++; if (!hit) begin bad++; $display("FAIL mid_reach got=0 exp=1"); end
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (wr_en !== 1'b0)    begin bad++; $display("FAIL mid_rst_wr_en got=%b exp=0", wr_en); end
    total++; if (wr_adr !== '0)     begin bad++; $display("FAIL mid_rst_adr got=%h exp=0", wr_adr); end
    total++; if (wr_dt !== '0)      begin bad++; $display("FAIL mid_rst_dt got=%h exp=0", wr_dt); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", clr_busy); end
    total++; if (clr_done !== 1'b0) begin bad++; $display("FAIL mid_rst_done got=%b exp=0", clr_done); end
    total++; if (gnt !== 2'b00)     begin bad++; $display("FAIL mid_rst_gnt got=%b exp=00", gnt); end
    step();
    rst_n = 1'b1;
    step();
    adr = {13'h0044, 13'h0033};
    dt  = {20'h44444, 20'h33333};
    req = 2'b11;
    step();
    total++; if (gnt !== 2'b01)       begin bad++; $display("FAIL post_rst_gnt got=%b exp=01", gnt); end
    total++; if (wr_adr !== 13'h0033) begin bad++; $display("FAIL post_rst_adr got=%h exp=0033", wr_adr); end
    total++; if (wr_dt !== 20'h33333) begin bad++; $display("FAIL post_rst_dt got=%h exp=33333", wr_dt); end
    req = 2'b00;
    for (int i = 0; i < 20; i++) begin
      step();
      if (clr_done) ndone++;
    end
    total++; if (ndone != 0)        begin bad++; $display("FAIL post_rst_done got=%0d exp=0", ndone); end
    total++; if (clr_busy !== 1'b0) begin bad++; $display("FAIL post_rst_busy got=%b exp=0", clr_busy); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_blank();
    test_clear(1);
    test_clear(2);
    test_reset_midclear();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vram_wr_sched.md
# vram_wr_sched

VRAM write scheduler for the VGA text pipeline. It shares the single VRAM write port (`vram_wr_adr` / `vram_wr_en` / data) between several requesters, such as a UART text writer and a debug overlay, using round-robin arbitration. It also includes a built-in full-screen clear engine. Writes can be restricted to blanking intervals so that the read path of `vram_ctrl` never sees a tearing update.

## Interface
Parameters:
- `P_NUM_REQ`, 2: number of write requesters (1..8).
- `P_ADR_BIT`, 13: VRAM address width.
- `P_DT_BIT`, 20: VRAM word width, laid out as {char[7:0], red[3:0], green[3:0], blue[3:0]}.
- `P_VRAM_DEPTH`, 4800: number of words swept by a clear (80x60 cells).
- `P_BLANK_ONLY`, 1: when 1, writes are issued only while `i_rgb_on` = 0.

Ports:
- `i_clk`, in, 1: system clock. Single clock domain.
- `i_rst_n`, in, 1: asynchronous, active-low reset.
- `i_rgb_on`, in, 1: active-video flag from syncgen.
- `i_vga_end`, in, 1: one-cycle end-of-frame pulse from syncgen.
- `i_req`, in, P_NUM_REQ: per-requester write request (level).
- `i_adr`, in, P_NUM_REQ*P_ADR_BIT: packed addresses; requester k occupies slice k.
- `i_dt`, in, P_NUM_REQ*P_DT_BIT: packed write data, same packing as `i_adr`.
- `o_gnt`, out, P_NUM_REQ: one-hot grant pulse, asserted in the same cycle as the write.
- `i_clr_req`, in, 1: one-cycle pulse requesting a full clear.
- `i_clr_dt`, in, P_DT_BIT: fill word for the clear.
- `o_clr_busy`, out, 1: high while a clear is pending or sweeping.
- `o_clr_done`, out, 1: one-cycle pulse when a clear finishes.
- `o_vram_wr_en`, out, 1: VRAM write strobe.
- `o_vram_wr_adr`, out, P_ADR_BIT: VRAM write address.
- `o_vram_wr_dt`, out, P_DT_BIT: VRAM write data.

## Operation
- The write window is open when `P_BLANK_ONLY` = 0, or when `i_rgb_on` = 0.
- FSM states are S_IDLE, S_WAIT_FRAME and S_CLEAR.
- S_IDLE, when the window is open:
  - Pick one eligible requester by round-robin. The search starts at the index after the last-granted one; after reset the search starts at 0.
  - A requester is eligible when its `i_req` = 1 and its `o_gnt` is not already high this cycle. This guarantees one write per request handshake.
  - Register the winner's address and data. In the next cycle, drive `o_vram_wr_en` = 1 and the one-hot `o_gnt`.
- S_IDLE, when the window is closed: no grant is issued and requests stay pending.
- Requester protocol:
  - Hold `i_req`, `i_adr` and `i_dt` stable until the cycle in which `o_gnt[k]` = 1.
  - In the following cycle, either drop `i_req` or present the next word.
  - Deasserting `i_req` before the grant is legal and withdraws the request.
- `i_clr_req` sets the clear-pending flag, which drives `o_clr_busy` high.
  - S_IDLE moves to S_WAIT_FRAME when pending is set and no write is issued this cycle.
  - S_WAIT_FRAME moves to S_CLEAR on `i_vga_end`. The clear counter is loaded with 0 and the pending flag is cleared.
  - S_CLEAR issues one write per open-window cycle at address `clr_cnt` with data `i_clr_dt`, then increments `clr_cnt`.
  - When the window is closed, S_CLEAR pauses and holds the counter.
  - After the write at address P_VRAM_DEPTH-1, the next cycle pulses `o_clr_done` and the FSM returns to S_IDLE.
  - `o_gnt` stays 0 in S_WAIT_FRAME and S_CLEAR.
- A new `i_clr_req` during S_WAIT_FRAME has no extra effect.
  - During S_CLEAR it re-sets pending, so a second full sweep follows.
  - In that case `o_clr_busy` stays high across both sweeps.
- `clr_cnt` is P_ADR_BIT wide. The comparison against P_VRAM_DEPTH-1 is unsigned, and the counter never wraps past that value.

## Timing
- Reset value of every output is 0. FSM state is S_IDLE, the round-robin pointer is 0, and the counter is 0.
- Grant latency is one cycle: a request accepted in cycle t produces `o_gnt` and `o_vram_wr_en` in cycle t+1.
- Throughput:
  - Across different requesters, one write per cycle.
  - For the same requester, at most one write every 2 cycles.
- Write outputs are registered with no combinational path from the inputs. `o_vram_wr_adr` and `o_vram_wr_dt` hold their last values when `o_vram_wr_en` = 0.
- If `i_rgb_on` rises in cycle t, the decision made in cycle t is suppressed, while the write issued in cycle t (decided in t-1) still completes.
- A clear sweep starts the cycle after the `i_vga_end` pulse.
- Asserting `i_rst_n` low mid-clear aborts the sweep. No `o_clr_done` is produced and `o_clr_busy` = 0 after reset.

## Structure
- `vga_pkg` holds:
  - the FSM enum `vsched_state_t` (S_IDLE, S_WAIT_FRAME, S_CLEAR);
  - the VRAM word field-offset constants;
  - the default depth of 4800.
- The only sub-module is `rr_arb`, a parameterized round-robin arbiter with one-hot output and an internal last-grant pointer. The enable input to `rr_arb` is window-open AND S_IDLE.

## Test plan
- Single requester, P_BLANK_ONLY = 0: req0 with adr = 0x0010, dt = 0x41F00. Expect `o_gnt` = 01 and a write of 0x0010 / 0x41F00 exactly one cycle later. Holding req0 for 6 cycles yields exactly 3 writes.
- Both requesters held continuously: grants alternate 01, 10, 01, 10. Each write carries its own requester's address and data, and no cycle has two grants.
- P_BLANK_ONLY = 1 with `i_rgb_on` = 1 for 100 cycles: zero writes occur. After `i_rgb_on` falls, the pending request is granted 1 cycle later.
- `i_clr_req` with `i_clr_dt` = 0x20000, followed by `i_vga_end`:
  - 4800 writes at addresses 0..4799, every one carrying 0x20000, and none during `rgb_on`;
  - `o_clr_done` pulses once, one cycle after the write to address 4799;
  - `o_clr_busy` is high from the cycle after `i_clr_req` until `o_clr_done`;
  - `o_gnt` stays 0 throughout.
- A second `i_clr_req` mid-sweep produces 9600 total writes and a single rise/fall of `o_clr_busy`.
- Reset asserted at sweep address 2000: all outputs become 0 immediately. After release, requesters are granted normally and no `o_clr_done` appears.
